weighted_steering_controller: RTL and testbench
===============================================

# weighted_steering_controller

Parametrised obstacle-avoidance steering controller for N binary distance sensors with per-sensor programmable weights. Each frame it snapshots the sensor array, speed and weights, scans one sensor per cycle into left/right/centre accumulators, and then produces signed differential wheel commands. It replaces the fixed-weight forward controller and feeds the task manager, which relays `wheel_left`/`wheel_right` to the servos.

## Interface
- `SENSOR_COUNT`, 5: number of sensors, ≥2. Bit 0 is rightmost, bit N-1 is leftmost.
- `WIDTH_SPEED`, 6: unsigned speed width.
- `WIDTH_CMD`, 8: signed wheel command width.
- `WIDTH_WEIGHT`, 4: unsigned per-sensor weight width.
- `SENSOR_ACTIVE_LOW`, 1: 1 means a raw 0 on a sensor input indicates an obstacle.
- `clk` in 1: single clock domain.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: run frames while high.
- `speed` in WIDTH_SPEED: base forward speed, unsigned.
- `sensor_array` in SENSOR_COUNT: raw sensor bits.
- `weights` in SENSOR_COUNT*WIDTH_WEIGHT: packed weights; sensor i uses bits [i*WIDTH_WEIGHT +: WIDTH_WEIGHT].
- `wheel_left`, `wheel_right` out WIDTH_CMD signed: registered wheel commands.
- `cmd_valid` out 1: one-cycle pulse when the wheel commands update.
- `busy` out 1: high while a frame is in progress (states SCAN and COMPUTE).

## Operation
- **Hit definition:** hit[i] = sensor_array[i] XOR SENSOR_ACTIVE_LOW, taken from the snapshot.
- **Sensor classes:**
  - MID = SENSOR_COUNT/2 (integer division).
  - Odd SENSOR_COUNT: sensor MID is the centre, i < MID is right side, i > MID is left side.
  - Even SENSOR_COUNT: there is no centre; i < MID is right side, i ≥ MID is left side.
- **FSM states:** IDLE, SAMPLE, SCAN, COMPUTE.
  - IDLE → SAMPLE when enable is high.
  - SAMPLE: register sensors, speed and weights; clear acc_l, acc_r and centre_hit; set idx=0.
  - SCAN: one sensor per cycle. Right-side hits add the sensor's weight to acc_r, left-side hits add it to acc_l, and a centre hit sets centre_hit. Leave SCAN after idx = SENSOR_COUNT-1.
  - COMPUTE: register the outputs, pulse cmd_valid, then go to SAMPLE. Framing is back-to-back.
- **Accumulator width:** WIDTH_WEIGHT + clog2(SENSOR_COUNT). Accumulators never overflow.
- **Command law** (s = zero-extended speed snapshot):
  - No centre hit: left = s − acc_r, right = s − acc_l. An obstacle on the right slows the left wheel, turning the robot left.
  - Centre hit and acc_r ≥ acc_l (including a 0/0 tie): pivot left, left = −s, right = +s.
  - Centre hit and acc_r < acc_l: pivot right, left = +s, right = −s.
  - Intermediate math uses max(WIDTH_SPEED, accumulator width) + 2 bits signed. The result saturates to [−(2^(WIDTH_CMD−1)−1), 2^(WIDTH_CMD−1)−1] (symmetric).
- **Input changes:** changes to sensors, speed or weights during a frame are ignored until the next SAMPLE.
- **enable low:** the next cycle goes to IDLE and outputs become 0. The frame in progress is discarded with no cmd_valid.
- **Reset:** has priority over enable. FSM goes to IDLE; wheel_left = wheel_right = 0, cmd_valid = 0, busy = 0; accumulators and idx are cleared.

## Timing
- Frame length is SENSOR_COUNT + 2 cycles (SAMPLE, N×SCAN, COMPUTE).
- enable rises at cycle 0 (IDLE sees it). SAMPLE is at cycle 1. The first cmd_valid and new outputs are visible after the edge ending COMPUTE, at cycle N+3. Subsequent cmd_valid pulses follow every N+2 cycles.
- Outputs hold between pulses.
- Weight or speed changes appear in outputs at most 2N+4 cycles after they are applied.
- busy is 0 in IDLE and SAMPLE.

## Structure
- **Shared package `steering_pkg`:**
  - State enum.
  - Accumulator-width function (clog2-based).
  - Saturation function parameterised by WIDTH_CMD.
- **Sub-module `cmd_saturate`:** signed clamp of one command to the symmetric WIDTH_CMD range. It is combinational and instantiated twice, once per wheel.

## Test plan
Defaults N=5, SENSOR_ACTIVE_LOW=0, weights w[0..4] = {3,1,5,1,3}, speed = 20.
- **No hits:** enable held high → cmd_valid first at cycle 8, then every 7 cycles; outputs left = 20, right = 20.
- **Right-side hit:** sensor 0 hit → left = 17, right = 20. Sensors 3 and 4 hit → left = 20, right = 16.
- **Centre with side hit:** sensors 2 and 0 hit → left = −20, right = 20. Sensors 2 and 4 hit → left = 20, right = −20.
- **Centre tie:** sensor 2 alone hit → left = −20, right = 20.
- **Saturation and negatives:**
  - WIDTH_CMD=5, no hits, speed = 20 → outputs 15, 15.
  - Default width, speed = 2, all weights 15, sensors 0 and 1 hit → left = −28, right = 2.
- **Abort:**
  - enable dropped in the 3rd SCAN cycle → outputs 0 next cycle, no cmd_valid.
  - reset asserted mid-frame with enable high → all outputs 0; a full frame restarts after reset is released.
  - SENSOR_ACTIVE_LOW=1 with raw input 5'b11110 → same as the sensor-0 hit case.

Source files
------------

// File: rtl/steering_pkg.sv
// Shared types and helpers for the weighted steering controller.
// State encoding, accumulator sizing and symmetric command clamp.
package steering_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SAMPLE,
        S_SCAN,
        S_COMPUTE
    } state_t;

    // Wide enough to hold the sum of every weight without overflow.
    function automatic int acc_width(input int ww, input int n);
        return ww + $clog2(n);
    endfunction

    // Clamp to the symmetric range +/-(2^(w-1)-1).
    function automatic logic signed [31:0] sat_cmd(
        input logic signed [31:0] v,
        input int                 w
    );
        logic signed [31:0] lim;
        lim = (32'sd1 <<< (w - 1)) - 32'sd1;
        if (v > lim) begin
            return lim;
        end else if (v < -lim) begin
            return -lim;
        end
        return v;
    endfunction

endpackage

// File: rtl/cmd_saturate.sv
// Combinational signed clamp of one wheel command.
// The negative limit mirrors the positive one so turns stay symmetric.
module cmd_saturate
    import steering_pkg::*;
#(
    parameter int IN_W      = 10,
    parameter int WIDTH_CMD = 8
) (
    input  logic signed [IN_W-1:0]      din,
    output logic signed [WIDTH_CMD-1:0] dout
);

    assign dout = WIDTH_CMD'(sat_cmd(32'(din), WIDTH_CMD));

endmodule

// File: rtl/weighted_steering_controller.sv
// Obstacle-avoidance steering with per-sensor weights.
// Snapshot, serial scan into side accumulators, then differential command.
module weighted_steering_controller
    import steering_pkg::*;
#(
    parameter int SENSOR_COUNT      = 5,
    parameter int WIDTH_SPEED       = 6,
    parameter int WIDTH_CMD         = 8,
    parameter int WIDTH_WEIGHT      = 4,
    parameter bit SENSOR_ACTIVE_LOW = 1'b1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 enable,
    input  logic [WIDTH_SPEED-1:0]               speed,
    input  logic [SENSOR_COUNT-1:0]              sensor_array,
    input  logic [SENSOR_COUNT*WIDTH_WEIGHT-1:0] weights,
    output logic signed [WIDTH_CMD-1:0]          wheel_left,
    output logic signed [WIDTH_CMD-1:0]          wheel_right,
    output logic                                 cmd_valid,
    output logic                                 busy
);

    localparam int ACC_W = acc_width(WIDTH_WEIGHT, SENSOR_COUNT);
    localparam int IDX_W = $clog2(SENSOR_COUNT);
    localparam int MW    = ((WIDTH_SPEED > ACC_W) ? WIDTH_SPEED : ACC_W) + 2;
    localparam bit ODD   = (SENSOR_COUNT % 2) == 1;
    localparam logic [IDX_W-1:0] MID_I  = IDX_W'(SENSOR_COUNT / 2);
    localparam logic [IDX_W-1:0] LAST_I = IDX_W'(SENSOR_COUNT - 1);

    state_t state_q, state_d;

    logic [IDX_W-1:0]        idx;
    logic [ACC_W-1:0]        acc_l, acc_r;
    logic                    centre_hit;
    logic [SENSOR_COUNT-1:0] hit_q;
    logic [WIDTH_SPEED-1:0]  speed_q;
    logic [WIDTH_WEIGHT-1:0] w_q [SENSOR_COUNT];

    logic                    is_centre, is_right;
    logic signed [MW-1:0]    s_ext, l_ext, r_ext, raw_l, raw_r;
    logic signed [WIDTH_CMD-1:0] sat_l, sat_r;

    assign busy      = (state_q == S_SCAN) || (state_q == S_COMPUTE);
    assign is_centre = ODD && (idx == MID_I);
    assign is_right  = idx < MID_I;

    assign s_ext = MW'(speed_q);
    assign l_ext = MW'(acc_l);
    assign r_ext = MW'(acc_r);

    // State register; reset wins over enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: back-to-back frames while enabled, drop to idle otherwise.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:    state_d = S_SAMPLE;
                S_SAMPLE:  state_d = S_SCAN;
                S_SCAN:    state_d = (idx == LAST_I) ? S_COMPUTE : S_SCAN;
                S_COMPUTE: state_d = S_SAMPLE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // Command law: steer away from the heavier side, pivot on a centre hit.
    always_comb begin
        raw_l = s_ext - r_ext;
        raw_r = s_ext - l_ext;
        if (centre_hit) begin
            if (acc_r >= acc_l) begin
                raw_l = -s_ext;
                raw_r = s_ext;
            end else begin
                raw_l = s_ext;
                raw_r = -s_ext;
            end
        end
    end

    cmd_saturate #(.IN_W(MW), .WIDTH_CMD(WIDTH_CMD)) u_sat_l (
        .din  (raw_l),
        .dout (sat_l)
    );

    cmd_saturate #(.IN_W(MW), .WIDTH_CMD(WIDTH_CMD)) u_sat_r (
        .din  (raw_r),
        .dout (sat_r)
    );

    // Snapshot, scan accumulation and registered command outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx         <= '0;
            acc_l       <= '0;
            acc_r       <= '0;
            centre_hit  <= 1'b0;
            hit_q       <= '0;
            speed_q     <= '0;
            w_q         <= '{default: '0};
            wheel_left  <= '0;
            wheel_right <= '0;
            cmd_valid   <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            if (!enable) begin
                wheel_left  <= '0;
                wheel_right <= '0;
            end else begin
                unique case (state_q)
                    S_SAMPLE: begin
                        hit_q      <= sensor_array ^ {SENSOR_COUNT{SENSOR_ACTIVE_LOW}};
                        speed_q    <= speed;
                        for (int i = 0; i < SENSOR_COUNT; i++) begin
                            w_q[i] <= weights[i*WIDTH_WEIGHT +: WIDTH_WEIGHT];
                        end
                        acc_l      <= '0;
                        acc_r      <= '0;
                        centre_hit <= 1'b0;
                        idx        <= '0;
                    end
                    S_SCAN: begin
                        if (hit_q[idx]) begin
                            unique case (1'b1)
                                is_centre: centre_hit <= 1'b1;
                                is_right:  acc_r <= acc_r + ACC_W'(w_q[idx]);
                                default:   acc_l <= acc_l + ACC_W'(w_q[idx]);
                            endcase
                        end
                        idx <= idx + 1'b1;
                    end
                    S_COMPUTE: begin
                        wheel_left  <= sat_l;
                        wheel_right <= sat_r;
                        cmd_valid   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_weighted_steering_controller.sv
// Bench for weighted_steering_controller: tables, corner sequences, random.
// Three instances: default, 5-bit commands, and active-low sensors.
module tb_weighted_steering_controller;

    localparam logic [19:0] DEFW = 20'h31513;
    localparam logic [19:0] ALLF = 20'hFFFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [5:0]  speed;
    logic [4:0]  sens;
    logic [4:0]  sens_n;
    logic [19:0] wts;

    logic signed [7:0] wl, wr, al_l, al_r;
    logic signed [4:0] w5_l, w5_r;
    logic cv, bz, cv5, bz5, cva, bza;

    int ncmp = 0;
    int nfail = 0;

    assign sens_n = ~sens;

    always #5 clk = ~clk;

    weighted_steering_controller #(
        .SENSOR_COUNT(5), .WIDTH_SPEED(6), .WIDTH_CMD(8),
        .WIDTH_WEIGHT(4), .SENSOR_ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .speed(speed),
        .sensor_array(sens), .weights(wts),
        .wheel_left(wl), .wheel_right(wr), .cmd_valid(cv), .busy(bz)
    );

    weighted_steering_controller #(
        .SENSOR_COUNT(5), .WIDTH_SPEED(6), .WIDTH_CMD(5),
        .WIDTH_WEIGHT(4), .SENSOR_ACTIVE_LOW(1'b0)
    ) dut_w5 (
        .clk(clk), .reset(reset), .enable(enable), .speed(speed),
        .sensor_array(sens), .weights(wts),
        .wheel_left(w5_l), .wheel_right(w5_r), .cmd_valid(cv5), .busy(bz5)
    );

    weighted_steering_controller #(
        .SENSOR_COUNT(5), .WIDTH_SPEED(6), .WIDTH_CMD(8),
        .WIDTH_WEIGHT(4), .SENSOR_ACTIVE_LOW(1'b1)
    ) dut_al (
        .clk(clk), .reset(reset), .enable(enable), .speed(speed),
        .sensor_array(sens_n), .weights(wts),
        .wheel_left(al_l), .wheel_right(al_r), .cmd_valid(cva), .busy(bza)
    );

    typedef struct {
        logic [4:0]  s;
        int          spd;
        logic [19:0] w;
        int          el, er, el5, er5;
    } vec_t;

    vec_t tbl [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!cv && n < 40);
        if (!cv) begin
            ncmp++;
            nfail++;
            $display("FAIL %s: cmd_valid got 0 expected 1 within 40 cycles", nm);
        end
    endtask

    // Spec-level model: sum side weights, apply the law, clamp.
    function automatic void model(
        input  logic [4:0]  hits,
        input  int          spd,
        input  logic [19:0] w,
        input  int          cw,
        output int          l,
        output int          r
    );
        int al, ar, lim;
        bit c;
        al = 0;
        ar = 0;
        c = 0;
        for (int i = 0; i < 5; i++) begin
            if (hits[i]) begin
                if (i < 2) ar += int'(w[i*4 +: 4]);
                else if (i == 2) c = 1;
                else al += int'(w[i*4 +: 4]);
            end
        end
        if (!c) begin
            l = spd - ar;
            r = spd - al;
        end else if (ar >= al) begin
            l = -spd;
            r = spd;
        end else begin
            l = spd;
            r = -spd;
        end
        lim = (1 << (cw - 1)) - 1;
        if (l > lim) l = lim;
        if (l < -lim) l = -lim;
        if (r > lim) r = lim;
        if (r < -lim) r = -lim;
    endfunction

    task automatic chk_all_zero(input string nm);
        chk({nm, "_wl"}, int'(wl), 0);
        chk({nm, "_wr"}, int'(wr), 0);
        chk({nm, "_cv"}, int'(cv), 0);
        chk({nm, "_busy"}, int'(bz), 0);
        chk({nm, "_w5l"}, int'(w5_l), 0);
        chk({nm, "_all"}, int'(al_l), 0);
    endtask

    initial begin
        int cnt, el, er, el5, er5;
        vec_t v;

        tbl[0]  = '{5'b00000, 20, DEFW,  20,  20,  15,  15};
        tbl[1]  = '{5'b00001, 20, DEFW,  17,  20,  15,  15};
        tbl[2]  = '{5'b11000, 20, DEFW,  20,  16,  15,  15};
        tbl[3]  = '{5'b00101, 20, DEFW, -20,  20, -15,  15};
        tbl[4]  = '{5'b10100, 20, DEFW,  20, -20,  15, -15};
        tbl[5]  = '{5'b00100, 20, DEFW, -20,  20, -15,  15};
        tbl[6]  = '{5'b00011,  2, ALLF, -28,   2, -15,   2};
        tbl[7]  = '{5'b11111, 63, ALLF, -63,  63, -15,  15};
        tbl[8]  = '{5'b11011, 63, ALLF,  33,  33,  15,  15};
        tbl[9]  = '{5'b11000,  0, ALLF,   0, -30,   0, -15};
        tbl[10] = '{5'b00000, 63, DEFW,  63,  63,  15,  15};
        tbl[11] = '{5'b01010,  5, DEFW,   4,   4,   4,   4};

        reset  = 1'b1;
        enable = 1'b0;
        speed  = 6'd20;
        sens   = 5'b00000;
        wts    = DEFW;
        repeat (3) tick();
        chk_all_zero("reset");

        reset = 1'b0;
        tick();
        enable = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            tick();
            chk($sformatf("timing_cv_c%0d", k), int'(cv),
                int'(k >= 8 && (k - 8) % 7 == 0));
            chk($sformatf("timing_busy_c%0d", k), int'(bz),
                int'((k - 1) % 7 != 0));
            if (k == 8) begin
                chk("first_wl", int'(wl), 20);
                chk("first_wr", int'(wr), 20);
            end
        end

        foreach (tbl[i]) begin
            sens  = tbl[i].s;
            speed = 6'(tbl[i].spd);
            wts   = tbl[i].w;
            wait_valid($sformatf("tbl%0d_wait", i));
            chk($sformatf("tbl%0d_wl", i), int'(wl), tbl[i].el);
            chk($sformatf("tbl%0d_wr", i), int'(wr), tbl[i].er);
            chk($sformatf("tbl%0d_w5l", i), int'(w5_l), tbl[i].el5);
            chk($sformatf("tbl%0d_w5r", i), int'(w5_r), tbl[i].er5);
            chk($sformatf("tbl%0d_all", i), int'(al_l), tbl[i].el);
            chk($sformatf("tbl%0d_alr", i), int'(al_r), tbl[i].er);
        end

        repeat (3) tick();
        chk("abort_busy_before", int'(bz), 1);
        enable = 1'b0;
        tick();
        chk_all_zero("abort");
        cnt = 0;
        repeat (12) begin
            tick();
            if (cv) cnt++;
        end
        chk("abort_no_valid", cnt, 0);

        enable = 1'b1;
        wait_valid("reenable_wait");
        chk("reenable_wl", int'(wl), 4);
        chk("reenable_wr", int'(wr), 4);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk_all_zero("midreset");
        reset = 1'b0;
        cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("restart_cv_c%0d", k), int'(cv), int'(k == 8));
        end
        chk("restart_wl", int'(wl), 4);
        chk("restart_wr", int'(wr), 4);

        for (int i = 0; i < 40; i++) begin
            v.s   = 5'($urandom);
            v.spd = int'($urandom_range(0, 63));
            v.w   = 20'($urandom);
            model(v.s, v.spd, v.w, 8, el, er);
            model(v.s, v.spd, v.w, 5, el5, er5);
            sens  = v.s;
            speed = 6'(v.spd);
            wts   = v.w;
            tick();
            sens  = 5'($urandom);
            speed = 6'($urandom);
            wts   = 20'($urandom);
            wait_valid($sformatf("rnd%0d_wait", i));
            chk($sformatf("rnd%0d_wl", i), int'(wl), el);
            chk($sformatf("rnd%0d_wr", i), int'(wr), er);
            chk($sformatf("rnd%0d_w5l", i), int'(w5_l), el5);
            chk($sformatf("rnd%0d_w5r", i), int'(w5_r), er5);
            chk($sformatf("rnd%0d_all", i), int'(al_l), el);
            chk($sformatf("rnd%0d_alr", i), int'(al_r), er);
            chk($sformatf("rnd%0d_cv5", i), int'(cv5), 1);
            chk($sformatf("rnd%0d_cva", i), int'(cva), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
